cla_share_arbiter: RTL and testbench
====================================

Name: cla_share_arbiter

Overview:
Time-shares a single 32-bit cla adder instance among N_REQ independent requesters. Each requester submits operands (a, b, cin) on a valid/ready handshake. A round-robin arbiter grants one request at a time, and the block returns a registered sum, carry-out and requester id on a valid/ready response channel. The block sits between request sources (for example button/LED demo logic and test counters) and the one shared adder.

Parameters:
N_REQ, 4, number of requesters; legal range 2..8.
ID_W, $clog2(N_REQ), width of the requester id (localparam, derived, not overridable).
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
req_valid  input  N_REQ  per-requester request valid.
req_ready  output  N_REQ  per-requester accept strobe; at most one bit set.
req_a  input  N_REQ*32  packed operand A; requester i occupies bits [32*i+31:32*i].
req_b  input  N_REQ*32  packed operand B; same packing as req_a.
req_cin  input  N_REQ  per-requester carry-in.
rsp_valid  output  1  response valid.
rsp_ready  input  1  response consumer ready.
rsp_sum  output  32  registered sum from cla.
rsp_cout  output  1  registered carry-out of bit 31.
rsp_id  output  ID_W  index of the requester that owns the response.
busy  output  1  high whenever the state is not IDLE.
op_count  output  CNT_W  count of completed responses; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0; op_count=0; busy=0.
  - Round-robin pointer last_grant=N_REQ-1, so requester 0 has highest priority first.
- FSM has three states, IDLE -> CALC -> RESP -> IDLE.
- IDLE:
  - If any req_valid bit is set, grant g = first set bit searching from last_grant+1 upward, wrapping modulo N_REQ.
  - req_ready[g]=1 combinationally in this cycle only. The handshake occurs when req_valid[g] && req_ready[g].
  - On the handshake edge: latch a_q, b_q, cin_q and id_q=g; set last_grant=g; go to CALC.
  - If no req_valid bit is set: stay in IDLE; req_ready is all zero.
- CALC:
  - a_q, b_q and cin_q drive the cla instance.
  - On the edge: rsp_sum<=sum; rsp_cout<=(a_q[31]&b_q[31]) | ((a_q[31]^b_q[31]) & ~sum[31]); rsp_id<=id_q; rsp_valid<=1; go to RESP.
- RESP:
  - rsp_* outputs hold stable while rsp_valid && !rsp_ready.
  - When rsp_ready=1: rsp_valid<=0, op_count<=op_count+1, go to IDLE. rsp_sum, rsp_cout and rsp_id keep their last values.
- req_ready is 0 in CALC and RESP. A requester must hold its valid and operands stable until it is accepted.
- Timing:
  - Latency: request accepted at edge T, rsp_valid high from T+1, first observable in the cycle after CALC, i.e. 2 cycles after the accept cycle.
  - Maximum throughput: one operation per 3 cycles.
- Fairness: a continuously asserting requester waits at most N_REQ-1 grants.
- Wrap-around:
  - 0xFFFFFFFF + 0x00000000 with cin=1 gives rsp_sum=0, rsp_cout=1.
  - op_count wraps to 0 after 2^CNT_W-1.
- Simultaneous events:
  - A req_valid that deasserts in a non-IDLE state is simply not served. No request is queued.
  - A requester re-asserting in the same IDLE cycle is handled by the pointer rule only.
- Reset mid-operation: in-flight operation is discarded, no response is issued, and the pointer returns to N_REQ-1.
- rsp_ready asserted outside RESP has no effect.

Decomposition:
- Package cla_ctrl_pkg:
  - state enum {IDLE, CALC, RESP}.
  - localparam DATA_W=32.
  - carry-out helper function.
- Sub-module rr_arbiter (N param): inputs req[N], last_grant, en; outputs one-hot grant, grant_idx, any.
- The existing cla module is instantiated once inside the block, unmodified.

Test Plan:
- Reset with all req_valid=0 -> rsp_valid=0, req_ready=0, busy=0, op_count=0.
- Req1 only, a=26, b=5, cin=0, rsp_ready=1 -> req_ready=4'b0010 for one cycle; rsp_valid 2 cycles later with rsp_sum=31, rsp_cout=0, rsp_id=1; op_count=1.
- Req0 with a=0xFFFFFFFF, b=0, cin=1 -> rsp_sum=0, rsp_cout=1.
- All four requesters held valid, rsp_ready=1 -> grant order 0,1,2,3,0; each response carries its own operands' sum.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready all 0, op_count unchanged; then rsp_ready=1 -> IDLE next cycle.
- Assert rst_n=0 during CALC -> no response, outputs at reset values; next grant goes to requester 0.

Source files
------------

// File: rtl/cla_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : cla_ctrl_pkg
// Brief   : Shared types and helpers for the time-shared CLA arbiter block.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package cla_ctrl_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Carry out of the MSB, recovered from the operand MSBs and the sum MSB.
    function automatic logic carry_out(input logic a_msb, input logic b_msb, input logic sum_msb);
        return (a_msb & b_msb) | ((a_msb ^ b_msb) & ~sum_msb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : cla
// Brief   : W-bit adder, 4-bit lookahead groups with group-level carry lookahead.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module cla #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum
);

    localparam int NG = W / 4;

    logic [W-1:0]  w_g;
    logic [W-1:0]  w_p;
    logic [W-1:0]  w_c;
    logic [NG:0]   w_gc;
    logic          w_acc;
    logic          w_grp_g;
    logic          w_grp_p;
    logic          w_unused_cout;

    assign w_g = a & b;
    assign w_p = a ^ b;

    always_comb begin
        w_gc    = '0;
        w_c     = '0;
        w_acc   = 1'b0;
        w_grp_g = 1'b0;
        w_grp_p = 1'b1;
        w_gc[0] = cin;
        for (int k = 0; k < NG; k++) begin
            // Group generate/propagate do not depend on the incoming carry.
            w_grp_g = 1'b0;
            w_grp_p = 1'b1;
            for (int j = 0; j < 4; j++) begin
                w_grp_g = w_g[4*k+j] | (w_p[4*k+j] & w_grp_g);
                w_grp_p = w_grp_p & w_p[4*k+j];
            end
            w_gc[k+1] = w_grp_g | (w_grp_p & w_gc[k]);
            w_acc = w_gc[k];
            for (int j = 0; j < 4; j++) begin
                w_c[4*k+j] = w_acc;
                w_acc = w_g[4*k+j] | (w_p[4*k+j] & w_acc);
            end
        end
    end

    assign sum           = w_p ^ w_c;
    assign w_unused_cout = w_gc[NG];

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : rr_arbiter
// Brief   : Round-robin arbiter; searches upward from last_grant+1 with wrap.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic w_found;
    int   w_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        any       = |req;
        for (int k = 1; k <= N; k++) begin
            w_idx = (int'(last_grant) + k) % N;
            if (!w_found && req[IW'(w_idx)]) begin
                w_found   = 1'b1;
                grant_idx = IW'(w_idx);
            end
        end
        if (en && w_found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cla_share_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : cla_share_arbiter
// Brief   : Round-robin time-sharing of one 32-bit CLA among N_REQ requesters.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module cla_share_arbiter
    import cla_ctrl_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int CNT_W = 16,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*32-1:0]   req_a,
    input  logic [N_REQ*32-1:0]   req_b,
    input  logic [N_REQ-1:0]      req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_sum,
    output logic                  rsp_cout,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  busy,
    output logic [CNT_W-1:0]      op_count
);

    state_t              r_state;
    state_t              w_next;
    logic [ID_W-1:0]     r_last;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_cin;
    logic [N_REQ-1:0]    w_grant;
    logic [ID_W-1:0]     w_idx;
    logic                w_any;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic                w_cin;
    logic [DATA_W-1:0]   w_sum;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req        (req_valid),
        .last_grant (r_last),
        .en         (r_state == IDLE),
        .grant      (w_grant),
        .grant_idx  (w_idx),
        .any        (w_any)
    );

    cla #(.W(DATA_W)) u_cla (
        .a   (r_a),
        .b   (r_b),
        .cin (r_cin),
        .sum (w_sum)
    );

    always_comb begin
        w_a   = '0;
        w_b   = '0;
        w_cin = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_idx == ID_W'(i)) begin
                w_a   = req_a[32*i +: 32];
                w_b   = req_b[32*i +: 32];
                w_cin = req_cin[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = CALC;
            CALC:    w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != IDLE);
        req_ready = w_grant;
    end

    // Operand capture, response registers and pointer share the FSM timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_cin     <= 1'b0;
            r_id      <= '0;
            r_last    <= ID_W'(N_REQ - 1);
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
            op_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a    <= w_a;
                        r_b    <= w_b;
                        r_cin  <= w_cin;
                        r_id   <= w_idx;
                        r_last <= w_idx;
                    end
                end
                CALC: begin
                    rsp_sum   <= w_sum;
                    rsp_cout  <= carry_out(r_a[DATA_W-1], r_b[DATA_W-1], w_sum[DATA_W-1]);
                    rsp_id    <= r_id;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cla_share_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_cla_share_arbiter
// Brief   : Directed self-checking bench for cla_share_arbiter (N_REQ=4).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_cla_share_arbiter;

    logic          clk;
    logic          rst_n;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [127:0]  req_a;
    logic [127:0]  req_b;
    logic [3:0]    req_cin;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_sum;
    logic          rsp_cout;
    logic [1:0]    rsp_id;
    logic          busy;
    logic [15:0]   op_count;

    int            n_tests;
    int            n_fail;
    logic [15:0]   exp_cnt;

    cla_share_arbiter #(.N_REQ(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One isolated request from requester id; caller sits at a negedge in IDLE.
    task automatic single(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic [31:0] es, input logic ec);
        @(negedge clk);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_cin[id]        = cin;
        req_valid          = 4'b0001 << id;
        #1;
        check("single_ready", 64'(req_ready), 64'(4'b0001 << id));
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        check("single_calc_ready", 64'(req_ready), 64'd0);
        check("single_calc_busy", 64'(busy), 64'd1);
        check("single_calc_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("single_rsp_valid", 64'(rsp_valid), 64'd1);
        check("single_rsp_sum", 64'(rsp_sum), 64'(es));
        check("single_rsp_cout", 64'(rsp_cout), 64'(ec));
        check("single_rsp_id", 64'(rsp_id), 64'(id));
        @(negedge clk);
        exp_cnt++;
        check("single_done_valid", 64'(rsp_valid), 64'd0);
        check("single_done_busy", 64'(busy), 64'd0);
        check("single_done_cnt", 64'(op_count), 64'(exp_cnt));
        check("single_hold_sum", 64'(rsp_sum), 64'(es));
    endtask

    initial begin
        logic [32:0] t;
        int          g;

        n_tests   = 0;
        n_fail    = 0;
        exp_cnt   = '0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cnt", 64'(op_count), 64'd0);
        check("rst_sum", 64'(rsp_sum), 64'd0);
        rst_n = 1'b1;

        single(1, 32'd26, 32'd5, 1'b0, 32'd31, 1'b0);
        single(0, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1);
        single(2, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1);
        single(3, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0);

        // All four held valid; pointer sits at 3 so order is 0,1,2,3,0.
        for (int i = 0; i < 4; i++) begin
            req_a[32*i +: 32] = 32'h4000_0000 * i + 32'h10 * i;
            req_b[32*i +: 32] = 32'h5000_0000 + i;
            req_cin[i]        = i[0];
        end
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            check("rr_ready", 64'(req_ready), 64'(4'b0001 << g));
            @(negedge clk);
            @(negedge clk);
            t = {1'b0, req_a[32*g +: 32]} + {1'b0, req_b[32*g +: 32]} + 33'(req_cin[g]);
            check("rr_id", 64'(rsp_id), 64'(g));
            check("rr_sum", 64'(rsp_sum), 64'(t[31:0]));
            check("rr_cout", 64'(rsp_cout), 64'(t[32]));
            @(negedge clk);
            exp_cnt++;
        end
        req_valid = 4'b0000;
        check("rr_cnt", 64'(op_count), 64'(exp_cnt));

        // Back-pressure: response must hold while rsp_ready is low.
        rsp_ready        = 1'b0;
        req_a[64 +: 32]  = 32'd7;
        req_b[64 +: 32]  = 32'd8;
        req_cin[2]       = 1'b0;
        req_valid        = 4'b0100;
        #1;
        check("stall_ready", 64'(req_ready), 64'b0100);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        req_valid = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_valid", 64'(rsp_valid), 64'd1);
            check("stall_sum", 64'(rsp_sum), 64'd15);
            check("stall_id", 64'(rsp_id), 64'd2);
            check("stall_req_ready", 64'(req_ready), 64'd0);
            check("stall_cnt", 64'(op_count), 64'(exp_cnt));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        check("release_busy", 64'(busy), 64'd0);
        check("release_valid", 64'(rsp_valid), 64'd0);
        check("release_cnt", 64'(op_count), 64'(exp_cnt));
        check("release_next_grant", 64'(req_ready), 64'b0001);
        req_valid = 4'b0000;

        // Reset during CALC discards the operation and rewinds the pointer.
        #1;
        req_valid = 4'b1000;
        #1;
        check("mid_ready", 64'(req_ready), 64'b1000);
        @(negedge clk);
        req_valid = 4'b0000;
        check("mid_calc_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_cnt", 64'(op_count), 64'd0);
        check("mid_rst_sum", 64'(rsp_sum), 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = '0;
        @(negedge clk);
        check("post_rst_valid", 64'(rsp_valid), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        req_valid = 4'b1111;
        #1;
        check("post_rst_grant", 64'(req_ready), 64'b0001);
        req_valid = 4'b0000;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
